rf_wb_arbiter: RTL and testbench

- Shares the register bank's single write port among NUM_REQ writeback requesters (e.g. 0 = ALU, 1 = LSU, 2 = CSR).
- Arbitrates round-robin and accepts at most one write per cycle.
- Registers the winning write and drives the bank's one-hot write-enable vector [31:1] and write data one cycle after acceptance.
- Sits between the execute/memory writeback sources and the register bank. Also provides a forwarding view of the write in flight and a saturating conflict counter.

---
 rtl/rf_wb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among NUM_REQ writeback sources.
// The winning write is registered and presented to the bank one cycle after acceptance.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_hold,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [NUM_REQ*5-1:0]    i_req_rd,
    input  logic [NUM_REQ*32-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic [31:1]             o_addr_w,
    output logic [31:0]             o_wdata,
    output logic                    o_fwd_valid,
    output logic [4:0]              o_fwd_rd,
    output logic [CNT_W-1:0]        o_conflict_cnt
);

    localparam int RD_W   = 5;
    localparam int DATA_W = 32;
    localparam int PTR_W  = $clog2(NUM_REQ);

    localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]   LAST_IDX = PTR_W'(NUM_REQ - 32'sd1);
    localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [PTR_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] vec);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = vec[k] ? PTR_W'(k) : idx;
        end
        return idx;
    endfunction

    logic [PTR_W-1:0]    ptr_r;
    logic [NUM_REQ-1:0]  upper_mask_s;
    logic [NUM_REQ-1:0]  upper_valid_s;
    logic [PTR_W-1:0]    gnt_idx_s;
    logic                grant_en_s;
    logic                conflict_s;
    logic [RD_W-1:0]     rd_arr_s   [NUM_REQ];
    logic [DATA_W-1:0]   data_arr_s [NUM_REQ];
    logic [RD_W-1:0]     sel_rd_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [31:1]         dec_s;

    // Unpack the per-requester buses and mark requesters at or above the pointer.
    always_comb begin
        upper_mask_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rd_arr_s[k]     = i_req_rd[k*RD_W +: RD_W];
            data_arr_s[k]   = i_req_data[k*DATA_W +: DATA_W];
            upper_mask_s[k] = (PTR_W'(k) >= ptr_r);
        end
    end

    // Rotating priority: first valid at/after ptr, otherwise wrap to the lowest valid.
    always_comb begin
        upper_valid_s = i_req_valid & upper_mask_s;
        grant_en_s    = (|i_req_valid) & ~i_hold & ~i_rst;
        if (|upper_valid_s) begin
            gnt_idx_s = lowest_idx(upper_valid_s);
        end else begin
            gnt_idx_s = lowest_idx(i_req_valid);
        end
    end

    // One-hot grant, suppressed while held, idle or in reset.
    always_comb begin
        if (grant_en_s) begin
            o_req_ready = REQ_ONE << gnt_idx_s;
        end else begin
            o_req_ready = '0;
        end
    end

    // Winner's payload and the decoded bank enable; x0 decodes to no enable.
    always_comb begin
        sel_rd_s   = rd_arr_s[gnt_idx_s];
        sel_data_s = data_arr_s[gnt_idx_s];
        dec_s      = '0;
        for (int b = 1; b < 32; b++) begin
            dec_s[b] = (sel_rd_s == RD_W'(b));
        end
    end

    // Two or more valid requests: clearing the lowest set bit leaves something behind.
    always_comb begin
        conflict_s = |(i_req_valid & (i_req_valid - REQ_ONE));
    end

    // Round-robin pointer moves just past the last winner.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_r <= '0;
        end else if (grant_en_s) begin
            ptr_r <= (gnt_idx_s == LAST_IDX) ? '0 : gnt_idx_s + PTR_ONE;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Write stage: payload holds across idle cycles, enables only pulse on a grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_addr_w    <= '0;
            o_wdata     <= '0;
            o_fwd_valid <= 1'b0;
            o_fwd_rd    <= '0;
        end else if (grant_en_s) begin
            o_addr_w    <= dec_s;
            o_wdata     <= sel_data_s;
            o_fwd_valid <= |dec_s;
            o_fwd_rd    <= sel_rd_s;
        end else begin
            o_addr_w    <= '0;
            o_fwd_valid <= 1'b0;
        end
    end

    // Saturating count of contended cycles, counted whether or not the port is held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_conflict_cnt <= '0;
        end else if (conflict_s && (o_conflict_cnt != '1)) begin
            o_conflict_cnt <= o_conflict_cnt + CNT_ONE;
        end else begin
            o_conflict_cnt <= o_conflict_cnt;
        end
    end

    rf_wb_arbiter_chk #(
        .NUM_REQ (NUM_REQ)
    ) u_chk (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_ready (o_req_ready),
        .i_addr_w    (o_addr_w),
        .i_fwd_valid (o_fwd_valid)
    );

endmodule

// Protocol properties of the arbiter outputs.
module rf_wb_arbiter_chk #(
    parameter int NUM_REQ = 3
) (
    input logic                i_clk,
    input logic                i_rst,
    input logic [NUM_REQ-1:0]  i_req_valid,
    input logic [NUM_REQ-1:0]  i_req_ready,
    input logic [31:1]         i_addr_w,
    input logic                i_fwd_valid
);

    a_ready_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(i_req_ready));

    a_ready_needs_valid: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_req_ready & ~i_req_valid) == '0);

    a_addr_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(i_addr_w));

    a_fwd_matches_addr: assert property (@(posedge i_clk) disable iff (i_rst)
        i_fwd_valid == (|i_addr_w));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (NUM_REQ=3, CNT_W=4) with hand-computed expectations.
module tb_rf_wb_arbiter;

    logic          clk;
    logic          rst;
    logic          hold;
    logic [2:0]    valid;
    logic [14:0]   rd_bus;
    logic [95:0]   data_bus;
    logic [2:0]    ready;
    logic [31:1]   addr_w;
    logic [31:0]   wdata;
    logic          fwd_valid;
    logic [4:0]    fwd_rd;
    logic [3:0]    cnt;

    int total;
    int bad;

    rf_wb_arbiter #(
        .NUM_REQ (3),
        .CNT_W   (4)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_hold         (hold),
        .i_req_valid    (valid),
        .i_req_rd       (rd_bus),
        .i_req_data     (data_bus),
        .o_req_ready    (ready),
        .o_addr_w       (addr_w),
        .o_wdata        (wdata),
        .o_fwd_valid    (fwd_valid),
        .o_fwd_rd       (fwd_rd),
        .o_conflict_cnt (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        rd_bus   = {r2, r1, r0};
        data_bus = {d2, d1, d0};
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    logic [3:0] exp_cnt;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        hold  = 1'b0;
        valid = 3'b001;
        set_req(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

        // reset state
        #2;
        chk("rst_ready", {29'd0, ready}, 32'h0);
        chk("rst_addr", {1'b0, addr_w}, 32'h0);
        chk("rst_cnt", {28'd0, cnt}, 32'h0);
        chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'h0);
        tick();
        rst = 1'b0;

        // first write after reset
        set_req(5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
        #1;
        chk("first_ready", {29'd0, ready}, 32'h1);
        tick();
        chk("first_addr", {1'b0, addr_w}, 32'h10);
        chk("first_wdata", wdata, 32'hDEADBEEF);
        chk("first_fwd_valid", {31'd0, fwd_valid}, 32'h1);
        chk("first_fwd_rd", {27'd0, fwd_rd}, 32'd5);
        valid = 3'b000;

        // round robin, no bubbles
        pulse_reset();
        valid = 3'b111;
        set_req(5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_ready", {29'd0, ready}, 32'h1 << (i % 3));
            tick();
            chk("rr_addr", {1'b0, addr_w}, 32'h1 << (i % 3));
            chk("rr_wdata", wdata, 32'hA0 + (i % 3));
        end
        valid = 3'b000;
        chk("rr_cnt", {28'd0, cnt}, 32'd6);
        tick();
        chk("idle_addr", {1'b0, addr_w}, 32'h0);
        chk("idle_fwd_valid", {31'd0, fwd_valid}, 32'h0);
        chk("idle_wdata_hold", wdata, 32'hA2);
        chk("idle_rd_hold", {27'd0, fwd_rd}, 32'd3);

        // x0 write discarded, pointer still advances
        valid = 3'b010;
        set_req(5'd1, 5'd0, 5'd3, 32'hA0, 32'h1234, 32'hA2);
        #1;
        chk("x0_ready", {29'd0, ready}, 32'h2);
        tick();
        chk("x0_addr", {1'b0, addr_w}, 32'h0);
        chk("x0_fwd_valid", {31'd0, fwd_valid}, 32'h0);
        chk("x0_wdata", wdata, 32'h1234);
        valid = 3'b110;
        #1;
        chk("x0_ptr2", {29'd0, ready}, 32'h4);
        valid = 3'b000;

        // hold blocks grants but not the conflict count
        pulse_reset();
        hold  = 1'b1;
        valid = 3'b101;
        set_req(5'd4, 5'd0, 5'd9, 32'hB0, 32'h0, 32'hB2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready", {29'd0, ready}, 32'h0);
            tick();
            chk("hold_addr", {1'b0, addr_w}, 32'h0);
        end
        chk("hold_cnt", {28'd0, cnt}, 32'd3);
        hold = 1'b0;
        #1;
        chk("release_ready", {29'd0, ready}, 32'h1);
        tick();
        chk("release_addr", {1'b0, addr_w}, 32'h8);
        chk("release_wdata", wdata, 32'hB0);
        chk("release_cnt", {28'd0, cnt}, 32'd4);

        // counter saturation
        valid   = 3'b011;
        exp_cnt = 4'd4;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_cnt = (exp_cnt == 4'd15) ? 4'd15 : exp_cnt + 4'd1;
            chk("sat_cnt", {28'd0, cnt}, {28'd0, exp_cnt});
        end
        valid = 3'b000;
        tick();
        chk("sat_hold_cnt", {28'd0, cnt}, 32'd15);

        // async reset mid-stream
        pulse_reset();
        valid = 3'b001;
        set_req(5'd3, 5'd7, 5'd0, 32'hC0, 32'hC1, 32'h0);
        #1;
        chk("mr_ready0", {29'd0, ready}, 32'h1);
        tick();
        chk("mr_addr0", {1'b0, addr_w}, 32'h4);
        valid = 3'b010;
        #1;
        chk("mr_ready1", {29'd0, ready}, 32'h2);
        rst = 1'b1;
        #1;
        chk("mr_addr_clear", {1'b0, addr_w}, 32'h0);
        chk("mr_ready_rst", {29'd0, ready}, 32'h0);
        chk("mr_fwd_clear", {31'd0, fwd_valid}, 32'h0);
        tick();
        chk("mr_addr_stay", {1'b0, addr_w}, 32'h0);
        rst   = 1'b0;
        valid = 3'b011;
        #1;
        chk("mr_prio0", {29'd0, ready}, 32'h1);
        tick();
        chk("mr_addr_after", {1'b0, addr_w}, 32'h4);
        valid = 3'b000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
